// File: rtl/memory_controller.sv
// Word-addressed RAM behind a req/ack handshake: configurable wait states,
// per-lane write enables, registered read data and a post-reset clear sweep.
module memory_controller #(
    parameter int word_size   = 16,
    parameter int addr_size   = 8,
    parameter int lane_size   = 8,
    parameter int wait_states = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic                           w_en,
    input  logic [addr_size-1:0]           addr,
    input  logic [word_size-1:0]           d_in,
    input  logic [word_size/lane_size-1:0] be,
    output logic [word_size-1:0]           d_out,
    output logic                           ack,
    output logic                           busy
);
    localparam int LANES = word_size / lane_size;
    localparam int DEPTH = 2 ** addr_size;
    // A one-bit counter still exists when wait_states is 0; it simply never loads non-zero.
    localparam int CNT_W = (wait_states > 0) ? $clog2(wait_states + 1) : 1;
    localparam logic [CNT_W-1:0]     WAIT_LOAD = CNT_W'(wait_states);
    localparam logic [addr_size-1:0] LAST_ADDR = {addr_size{1'b1}};

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t                 state_r;
    logic [addr_size-1:0]   ptr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   w_en_r;
    logic [addr_size-1:0]   addr_r;
    logic [word_size-1:0]   d_in_r;
    logic [LANES-1:0]       be_r;
    logic [word_size-1:0]   d_out_r;
    logic                   ack_r;

    logic [word_size-1:0]   bank [0:DEPTH-1];

    logic                   mem_we_s;
    logic [addr_size-1:0]   mem_addr_s;
    logic [word_size-1:0]   mem_wdata_s;
    logic [LANES-1:0]       mem_lane_s;

    assign busy  = (state_r != ST_IDLE);
    assign d_out = d_out_r;
    assign ack   = ack_r;

    // Select the write source: clear sweep during INIT, completing write in BUSY
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = ptr_r;
        mem_wdata_s = {word_size{1'b0}};
        mem_lane_s  = {LANES{1'b0}};
        if (rst) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    mem_we_s   = 1'b1;
                    mem_lane_s = {LANES{1'b1}};
                end
                ST_BUSY: begin
                    if ((cnt_r == {CNT_W{1'b0}}) && w_en_r) begin
                        mem_we_s    = 1'b1;
                        mem_addr_s  = addr_r;
                        mem_wdata_s = d_in_r;
                        mem_lane_s  = be_r;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Lane-masked write port into the storage array
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we_s && mem_lane_s[i]) begin
                bank[mem_addr_s][i*lane_size +: lane_size] <= mem_wdata_s[i*lane_size +: lane_size];
            end
        end
    end

    // Controller FSM: clear sweep, request capture, wait countdown, completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_INIT;
            ptr_r   <= {addr_size{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            w_en_r  <= 1'b0;
            addr_r  <= {addr_size{1'b0}};
            d_in_r  <= {word_size{1'b0}};
            be_r    <= {LANES{1'b0}};
            d_out_r <= {word_size{1'b0}};
            ack_r   <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    ptr_r <= ptr_r + addr_size'(1);
                    if (ptr_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        w_en_r  <= w_en;
                        addr_r  <= addr;
                        d_in_r  <= d_in;
                        be_r    <= be;
                        cnt_r   <= WAIT_LOAD;
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        ack_r   <= 1'b1;
                        state_r <= ST_IDLE;
                        if (!w_en_r) begin
                            d_out_r <= bank[addr_r];
                        end
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_controller.sv
// Randomised bench for memory_controller: a timeline-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_memory_controller;
    localparam int AW    = 4;
    localparam int WS    = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, req0;
    logic        w_en;
    logic [3:0]  addr;
    logic [15:0] d_in;
    logic [1:0]  be;
    logic [15:0] d_out, d_out0;
    logic        ack, ack0, busy, busy0;

    int n_checks = 0;
    int n_fail   = 0;

    memory_controller #(.word_size(16), .addr_size(AW), .lane_size(8), .wait_states(WS)) dut (
        .clk(clk), .rst(rst), .req(req), .w_en(w_en), .addr(addr), .d_in(d_in), .be(be),
        .d_out(d_out), .ack(ack), .busy(busy)
    );

    memory_controller #(.word_size(16), .addr_size(AW), .lane_size(8), .wait_states(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .w_en(w_en), .addr(addr), .d_in(d_in), .be(be),
        .d_out(d_out0), .ack(ack0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: timestamps of edges, not a copy of the controller states
    logic [15:0] mmem [DEPTH];
    bit          valid = 1'b0;
    int          t = 0;
    int          idle_from = 0;
    int          done_at = 0;
    bit          pend = 1'b0;
    bit          p_we;
    logic [3:0]  p_a;
    logic [15:0] p_d;
    logic [1:0]  p_be;
    logic        m_busy = 1'b1;
    logic        m_ack = 1'b0;
    logic [15:0] m_dout = 16'h0000;

    always @(posedge clk) begin
        t++;
        m_ack = 1'b0;
        if (rst) begin
            valid     = 1'b1;
            idle_from = t + DEPTH;
            pend      = 1'b0;
            m_dout    = 16'h0000;
            foreach (mmem[i]) mmem[i] = 16'h0000;
        end else if (valid) begin
            if (pend && t == done_at) begin
                if (p_we) begin
                    for (int i = 0; i < 2; i++)
                        if (p_be[i]) mmem[p_a][i*8 +: 8] = p_d[i*8 +: 8];
                end else begin
                    m_dout = mmem[p_a];
                end
                m_ack     = 1'b1;
                pend      = 1'b0;
                idle_from = t;
            end else if (!m_busy && req) begin
                pend    = 1'b1;
                done_at = t + WS + 1;
                p_we    = w_en;
                p_a     = addr;
                p_d     = d_in;
                p_be    = be;
            end
        end
        m_busy = !valid || pend || (t < idle_from);
    end

    // Cycle-by-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        if (valid) begin
            chk("busy", busy, m_busy);
            chk("ack", ack, m_ack);
            chk("d_out", d_out, m_dout);
        end
    end

    // Entered and left on a negedge; returns at the negedge of the ack cycle.
    task automatic access(input bit sel, input bit we, input logic [3:0] a, input logic [15:0] d,
                          input logic [1:0] b, input bit noise, output int lat);
        int n;
        n = 0;
        while ((sel ? busy0 : busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(n), 32'd0);
        w_en = we; addr = a; d_in = d; be = b;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(negedge clk);
        req = 1'b0; req0 = 1'b0;
        lat = 1;
        while (!(sel ? ack0 : ack) && lat < 50) begin
            if (noise && !sel) begin
                req  = 1'($urandom);
                w_en = 1'($urandom);
                addr = 4'($urandom);
                d_in = 16'($urandom);
                be   = 2'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        req = 1'b0;
        if (lat >= 50) chk("ack_timeout", 32'(lat), 32'd0);
    endtask

    task automatic count_init(input string nm);
        int n;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    initial begin
        int lat, cnt;
        rst = 1'b1; req = 1'b0; req0 = 1'b0; w_en = 1'b0; addr = 4'h0; d_in = 16'h0000; be = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_dout", d_out, 16'h0000);
        count_init("init_len");

        for (int a = 0; a < DEPTH; a++) begin
            access(1'b0, 1'b0, 4'(a), 16'h0000, 2'b00, 1'b0, lat);
            chk("clear_read", d_out, 16'h0000);
        end

        access(1'b0, 1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b0, lat);
        chk("wr_latency", 32'(lat), 32'd4);
        access(1'b0, 1'b0, 4'd5, 16'h0000, 2'b00, 1'b0, lat);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_beef", d_out, 16'hBEEF);

        access(1'b0, 1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, lat);
        access(1'b0, 1'b1, 4'd3, 16'hABCD, 2'b01, 1'b0, lat);
        access(1'b0, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, lat);
        chk("lane_lo", d_out, 16'h12CD);
        access(1'b0, 1'b1, 4'd3, 16'h5500, 2'b10, 1'b0, lat);
        access(1'b0, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, lat);
        chk("lane_hi", d_out, 16'h55CD);
        access(1'b0, 1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, lat);
        chk("be0_ack_latency", 32'(lat), 32'd4);
        access(1'b0, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, lat);
        chk("be0_unchanged", d_out, 16'h55CD);

        access(1'b0, 1'b0, 4'd5, 16'h0000, 2'b00, 1'b1, lat);
        chk("noisy_latency", 32'(lat), 32'd4);
        chk("noisy_data", d_out, 16'hBEEF);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack) cnt++;
        end
        chk("dropped_no_ack", 32'(cnt), 32'd0);

        access(1'b0, 1'b1, 4'd6, 16'h0F0F, 2'b11, 1'b0, lat);
        access(1'b0, 1'b0, 4'd6, 16'h0000, 2'b00, 1'b0, lat);
        chk("b2b_latency", 32'(lat), 32'd4);
        chk("b2b_data", d_out, 16'h0F0F);

        access(1'b0, 1'b1, 4'd9, 16'h1111, 2'b11, 1'b0, lat);
        w_en = 1'b1; addr = 4'd9; d_in = 16'h7777; be = 2'b11; req = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_no_ack", ack, 1'b0);
        count_init("reinit_len");
        access(1'b0, 1'b0, 4'd9, 16'h0000, 2'b00, 1'b0, lat);
        chk("abort_cleared", d_out, 16'h0000);

        repeat (300) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), lat);
            chk("rand_latency", 32'(lat), 32'(WS + 2));
        end

        access(1'b1, 1'b0, 4'd7, 16'h0000, 2'b00, 1'b0, lat);
        chk("ws0_rd_latency", 32'(lat), 32'd2);
        chk("ws0_rd_data", d_out0, 16'h0000);
        access(1'b1, 1'b1, 4'd7, 16'hCAFE, 2'b11, 1'b0, lat);
        chk("ws0_wr_latency", 32'(lat), 32'd2);
        access(1'b1, 1'b0, 4'd7, 16'h0000, 2'b00, 1'b0, lat);
        chk("ws0_rd_cafe", d_out0, 16'hCAFE);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
